// File: rtl/mem_access_unit.sv
// mem_access_unit: issues load/store accesses on the data-memory bus, holds the
// pipeline until acknowledge or timeout, builds big-endian store lanes, owns the
// LL/SC link flag and flags misaligned accesses.
module mem_access_unit #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [5:0]  i_instr_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_load_data,
    output logic [1:0]  o_addr_last_two_bit,
    output logic        o_done,
    output logic        o_sc_result,
    output logic        o_addr_exc,
    output logic        o_bus_err
);
    // MIPS primary opcodes for the memory instructions
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SWL = 6'h2A;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SWR = 6'h2E;
    localparam logic [5:0] OP_LL  = 6'h30;
    localparam logic [5:0] OP_SC  = 6'h38;

    // Wait counter counts BUSY cycles; the last allowed cycle is BUS_TIMEOUT-1
    localparam int              CW        = (BUS_TIMEOUT < 2) ? 2 : $clog2(BUS_TIMEOUT + 1);
    localparam int              TO_LAST_I = (BUS_TIMEOUT > 0) ? (BUS_TIMEOUT - 1) : 0;
    localparam logic [CW-1:0]   TO_LAST   = TO_LAST_I[CW-1:0];
    localparam logic            TO_EN     = (BUS_TIMEOUT > 0) ? 1'b1 : 1'b0;
    localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           is_mem;
    logic           is_store;
    logic           misaligned;
    logic           accept;
    logic           sc_skip;
    logic           ack_take;
    logic           timeout_hit;
    logic [3:0]     be_calc;
    logic [31:0]    wdata_calc;
    logic [5:0]     op_r;
    logic           link_r;
    logic           sc_link_r;
    logic [CW-1:0]  wait_cnt_r;

    // Classify the presented opcode: memory op, store, and alignment fault
    always_comb begin
        is_mem     = 1'b1;
        is_store   = 1'b0;
        misaligned = 1'b0;
        case (i_instr_op)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: is_mem = 1'b1;
            OP_LH, OP_LHU:                 misaligned = i_addr[0];
            OP_LW, OP_LL:                  misaligned = (i_addr[1:0] != 2'b00);
            OP_SB, OP_SWL, OP_SWR:         is_store = 1'b1;
            OP_SH: begin
                is_store   = 1'b1;
                misaligned = i_addr[0];
            end
            OP_SW, OP_SC: begin
                is_store   = 1'b1;
                misaligned = (i_addr[1:0] != 2'b00);
            end
            default: is_mem = 1'b0;
        endcase
    end

    // Big-endian lane placement: offset 00 is bits [31:24] and be[3]
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = 32'h0000_0000;
        case (i_instr_op)
            OP_SB: begin
                be_calc    = 4'b1000 >> i_addr[1:0];
                wdata_calc = {4{i_store_data[7:0]}};
            end
            OP_SH: begin
                be_calc    = i_addr[1] ? 4'b0011 : 4'b1100;
                wdata_calc = {2{i_store_data[15:0]}};
            end
            OP_SW, OP_SC: wdata_calc = i_store_data;
            OP_SWL: begin
                case (i_addr[1:0])
                    2'b00:   begin be_calc = 4'b1111; wdata_calc = i_store_data; end
                    2'b01:   begin be_calc = 4'b0111; wdata_calc = {8'h00, i_store_data[31:8]}; end
                    2'b10:   begin be_calc = 4'b0011; wdata_calc = {16'h0000, i_store_data[31:16]}; end
                    default: begin be_calc = 4'b0001; wdata_calc = {24'h000000, i_store_data[31:24]}; end
                endcase
            end
            OP_SWR: begin
                case (i_addr[1:0])
                    2'b00:   begin be_calc = 4'b1000; wdata_calc = {i_store_data[7:0], 24'h000000}; end
                    2'b01:   begin be_calc = 4'b1100; wdata_calc = {i_store_data[15:0], 16'h0000}; end
                    2'b10:   begin be_calc = 4'b1110; wdata_calc = {i_store_data[23:0], 8'h00}; end
                    default: begin be_calc = 4'b1111; wdata_calc = i_store_data; end
                endcase
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = 32'h0000_0000;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus combinational stall / address-exception outputs
    always_comb begin
        state_next  = state;
        o_stall     = 1'b0;
        o_addr_exc  = 1'b0;
        accept      = 1'b0;
        sc_skip     = 1'b0;
        ack_take    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_valid && is_mem) begin
                    if (misaligned) begin
                        o_addr_exc = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        o_stall = 1'b1;
                        if ((i_instr_op == OP_SC) && !link_r) begin
                            sc_skip    = 1'b1;
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_BUSY;
                        end
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                o_stall = 1'b1;
                if (i_mem_ack) begin
                    ack_take   = 1'b1;
                    state_next = ST_DONE;
                end else if (TO_EN && (wait_cnt_r == TO_LAST)) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_DONE;
                end else begin
                    state_next = ST_BUSY;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus request, captured access fields, completion pulses and wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            o_mem_req           <= 1'b0;
            o_mem_we            <= 1'b0;
            o_mem_be            <= 4'b0000;
            o_mem_addr          <= 32'h0000_0000;
            o_mem_wdata         <= 32'h0000_0000;
            o_load_data         <= 32'h0000_0000;
            o_addr_last_two_bit <= 2'b00;
            o_done              <= 1'b0;
            o_sc_result         <= 1'b0;
            o_bus_err           <= 1'b0;
            op_r                <= 6'h00;
            sc_link_r           <= 1'b0;
            wait_cnt_r          <= CNT_ZERO;
        end else begin
            o_done      <= 1'b0;
            o_sc_result <= 1'b0;
            o_bus_err   <= 1'b0;
            if (accept) begin
                op_r                <= i_instr_op;
                o_mem_addr          <= {i_addr[31:2], 2'b00};
                o_mem_be            <= be_calc;
                o_mem_wdata         <= wdata_calc;
                o_addr_last_two_bit <= i_addr[1:0];
                sc_link_r           <= link_r;
                wait_cnt_r          <= CNT_ZERO;
                if (sc_skip) begin
                    o_done <= 1'b1;
                end else begin
                    o_mem_req <= 1'b1;
                    o_mem_we  <= is_store;
                end
            end else if (ack_take) begin
                o_load_data <= i_mem_rdata;
                o_mem_req   <= 1'b0;
                o_mem_we    <= 1'b0;
                o_done      <= 1'b1;
                o_sc_result <= (op_r == OP_SC) && sc_link_r;
            end else if (timeout_hit) begin
                o_mem_req <= 1'b0;
                o_mem_we  <= 1'b0;
                o_done    <= 1'b1;
                o_bus_err <= 1'b1;
            end else if (state == ST_BUSY) begin
                wait_cnt_r <= wait_cnt_r + CNT_ONE;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // LL/SC link flag: flush has priority over an LL completing in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            link_r <= 1'b0;
        end else if (i_flush) begin
            link_r <= 1'b0;
        end else if ((state == ST_DONE) && (op_r == OP_SC)) begin
            link_r <= 1'b0;
        end else if ((state == ST_DONE) && (op_r == OP_LL) && !o_bus_err) begin
            link_r <= 1'b1;
        end else begin
            link_r <= link_r;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed and random accesses checked against a
// byte-lane reference model and a link-flag model kept in the bench.
module tb_mem_access_unit;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SWL = 6'h2A;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SWR = 6'h2E;
    localparam logic [5:0] OP_LL  = 6'h30;
    localparam logic [5:0] OP_SC  = 6'h38;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [5:0]  i_instr_op = 6'h00;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_store_data = 32'h0;
    logic        i_flush = 1'b0;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = 32'h0;
    logic        o_stall, o_mem_req, o_mem_we, o_done, o_sc_result, o_addr_exc, o_bus_err;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_addr, o_mem_wdata, o_load_data;
    logic [1:0]  o_addr_last_two_bit;

    int checks = 0;
    int errors = 0;
    bit link_m = 1'b0;

    mem_access_unit #(.BUS_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_instr_op(i_instr_op),
        .i_addr(i_addr), .i_store_data(i_store_data), .i_flush(i_flush),
        .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_be(o_mem_be), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_load_data(o_load_data),
        .o_addr_last_two_bit(o_addr_last_two_bit), .o_done(o_done),
        .o_sc_result(o_sc_result), .o_addr_exc(o_addr_exc), .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mem_op(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
                          OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR, OP_LL, OP_SC};
    endfunction

    function automatic bit is_store_op(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR, OP_SC};
    endfunction

    // natural alignment requirement; partial-word ops have none
    function automatic int access_size(input logic [5:0] op);
        if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
        if (op inside {OP_LW, OP_LL, OP_SW, OP_SC}) return 4;
        return 1;
    endfunction

    // byte k of the word sits at address offset k (big-endian); decide per byte
    // whether it is written and which byte of rt (0 = most significant) lands there
    function automatic void model_store(input logic [5:0] op, input logic [1:0] a,
                                        input logic [31:0] rt,
                                        output logic [3:0] be, output logic [31:0] wd);
        int ai;
        ai = int'(a);
        be = 4'b0000;
        wd = 32'h0;
        for (int k = 0; k < 4; k++) begin
            bit en;
            int src;
            bit zero_fill;
            en = 1'b1; src = k; zero_fill = 1'b0;
            case (op)
                OP_SB:        begin en = (k == ai); src = 3; end
                OP_SH:        begin en = ((k / 2) == (ai / 2)); src = 2 + (k % 2); end
                OP_SW, OP_SC: begin en = 1'b1; src = k; end
                OP_SWL:       begin en = (k >= ai); src = k - ai; zero_fill = 1'b1; end
                OP_SWR:       begin en = (k <= ai); src = 3 - ai + k; zero_fill = 1'b1; end
                default:      begin en = 1'b1; src = -1; end
            endcase
            be[3-k] = en;
            if (src >= 0 && src <= 3 && !(zero_fill && !en))
                wd[31-8*k -: 8] = rt[31-8*src -: 8];
        end
    endfunction

    // one instruction from presentation to retirement, checking every cycle
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input int ack_lat, input logic [31:0] rdata, input bit flush_done);
        logic [3:0]  ebe;
        logic [31:0] ewd;
        bit mem, mis, st, skip, link_acc, acked, err;
        mem      = is_mem_op(op);
        mis      = mem && ((addr % access_size(op)) != 0);
        st       = is_store_op(op);
        skip     = (op == OP_SC) && !link_m;
        link_acc = link_m;
        acked    = 1'b0;
        model_store(op, addr[1:0], rt, ebe, ewd);
        @(posedge clk); #1;
        i_valid = 1'b1; i_instr_op = op; i_addr = addr; i_store_data = rt;
        @(negedge clk);
        chk("idle_done", 32'(o_done), 32'd0);
        if (!mem || mis) begin
            chk("noaccept_stall", 32'(o_stall), 32'd0);
            chk("addr_exc", 32'(o_addr_exc), 32'(mis));
            @(posedge clk); #1;
            i_valid = 1'b0;
            @(negedge clk);
            chk("noaccept_req", 32'(o_mem_req), 32'd0);
            chk("noaccept_done", 32'(o_done), 32'd0);
            return;
        end
        chk("accept_stall", 32'(o_stall), 32'd1);
        chk("accept_exc", 32'(o_addr_exc), 32'd0);
        @(posedge clk); #1;
        if (!skip) begin
            for (int n = 0; n < TIMEOUT; n++) begin
                i_mem_ack   = (n == ack_lat);
                i_mem_rdata = rdata;
                @(negedge clk);
                chk("busy_req", 32'(o_mem_req), 32'd1);
                chk("busy_stall", 32'(o_stall), 32'd1);
                chk("busy_done", 32'(o_done), 32'd0);
                chk("busy_we", 32'(o_mem_we), 32'(st));
                chk("busy_be", 32'(o_mem_be), 32'(ebe));
                chk("busy_addr", o_mem_addr, {addr[31:2], 2'b00});
                if (st) chk("busy_wdata", o_mem_wdata, ewd);
                @(posedge clk); #1;
                i_mem_ack = 1'b0;
                if (n == ack_lat) begin
                    acked = 1'b1;
                    break;
                end
            end
        end
        err = !skip && !acked;
        i_flush = flush_done;
        @(negedge clk);
        chk("done_pulse", 32'(o_done), 32'd1);
        chk("done_stall", 32'(o_stall), 32'd0);
        chk("done_req", 32'(o_mem_req), 32'd0);
        chk("done_bus_err", 32'(o_bus_err), 32'(err));
        chk("done_last2", 32'(o_addr_last_two_bit), 32'(addr[1:0]));
        chk("done_sc_result", 32'(o_sc_result), 32'((op == OP_SC) && link_acc && !err));
        if (acked) chk("done_load_data", o_load_data, rdata);
        if (flush_done) link_m = 1'b0;
        else if (op == OP_SC) link_m = 1'b0;
        else if (op == OP_LL && !err) link_m = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic flush_idle();
        @(posedge clk); #1;
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        link_m = 1'b0;
    endtask

    initial begin
        logic [5:0] ops [15];
        logic [31:0] ra;
        ops = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, OP_SB,
                OP_SH, OP_SWL, OP_SW, OP_SWR, OP_LL, OP_SC, OP_ADDI};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(o_mem_req), 32'd0);
        chk("rst_we", 32'(o_mem_we), 32'd0);
        chk("rst_be", 32'(o_mem_be), 32'd0);
        chk("rst_addr", o_mem_addr, 32'd0);
        chk("rst_wdata", o_mem_wdata, 32'd0);
        chk("rst_load", o_load_data, 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_sc", 32'(o_sc_result), 32'd0);
        chk("rst_berr", 32'(o_bus_err), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // directed cases
        run_op(OP_LW,  32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        run_op(OP_SB,  32'h0000_0203, 32'h1234_5678, 0, 32'h0, 1'b0);
        run_op(OP_SWL, 32'h0000_0301, 32'hAABB_CCDD, 1, 32'h0, 1'b0);
        run_op(OP_SWR, 32'h0000_0302, 32'hAABB_CCDD, 2, 32'h0, 1'b0);
        run_op(OP_SH,  32'h0000_0312, 32'hAABB_CCDD, 0, 32'h0, 1'b0);
        run_op(OP_LW,  32'h0000_0102, 32'h0, 0, 32'h0, 1'b0);
        run_op(OP_LH,  32'h0000_0105, 32'h0, 0, 32'h0, 1'b0);
        run_op(OP_ADDI, 32'h0000_0100, 32'h0, 0, 32'h0, 1'b0);
        run_op(OP_LL,  32'h0000_0400, 32'h0, 0, 32'h1111_2222, 1'b0);
        run_op(OP_SC,  32'h0000_0400, 32'h5555_6666, 0, 32'h0, 1'b0);
        run_op(OP_SC,  32'h0000_0400, 32'h5555_6666, 0, 32'h0, 1'b0);
        run_op(OP_LL,  32'h0000_0400, 32'h0, 0, 32'h0, 1'b0);
        flush_idle();
        run_op(OP_SC,  32'h0000_0400, 32'h7, 0, 32'h0, 1'b0);
        run_op(OP_LL,  32'h0000_0404, 32'h0, 1, 32'h0, 1'b1);
        run_op(OP_SC,  32'h0000_0404, 32'h7, 0, 32'h0, 1'b0);
        // timeouts: read never acked, store timeout keeps link, LL timeout does not set it
        run_op(OP_LW,  32'h0000_0500, 32'h0, -1, 32'h0, 1'b0);
        run_op(OP_LL,  32'h0000_0600, 32'h0, 0, 32'h0, 1'b0);
        run_op(OP_SW,  32'h0000_0604, 32'h9, -1, 32'h0, 1'b0);
        run_op(OP_SC,  32'h0000_0600, 32'h9, 3, 32'h0, 1'b0);
        run_op(OP_LL,  32'h0000_0700, 32'h0, -1, 32'h0, 1'b0);
        run_op(OP_SC,  32'h0000_0700, 32'h9, 0, 32'h0, 1'b0);

        // reset in the middle of BUSY, with an ack arriving around the reset
        @(posedge clk); #1;
        i_valid = 1'b1; i_instr_op = OP_LW; i_addr = 32'h0000_0800;
        @(posedge clk); #1;
        i_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("midrst_req_before", 32'(o_mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("midrst_req_after", 32'(o_mem_req), 32'd0);
        @(posedge clk); #1;
        i_mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_done", 32'(o_done), 32'd0);
        chk("late_ack_load", o_load_data, 32'd0);
        link_m = 1'b0;

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 2) != 0) ra[1:0] = 2'b00;
            run_op(ops[$urandom_range(0, 14)], ra, $urandom, int'($urandom_range(0, 4)),
                   $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
